key_cmd_scheduler: RTL and testbench

- Sits downstream of the per-key debounce filters and upstream of the capture/storage control logic.
- Turns up to NUM_KEYS debounced key levels into a serialized stream of key commands, one at a time.
- Each command carries the key index and a short/long-press classification and is delivered over a valid/ack handshake.
- Simultaneous or overlapping presses are arbitrated by fixed priority (lowest index wins). Presses that cannot be queued are reported.

---
 rtl/key_cmd_pkg.sv | 30 +++
 rtl/key_edge_latch.sv | 50 +++++
 rtl/key_cmd_scheduler.sv | 139 +++++++++++++
 tb/tb_key_cmd_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_pkg.sv
// Shared state encoding, default parameters and arbitration helper
// for the key command scheduler.
package key_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ISSUE = 2'd2
  } state_e;

  localparam int NUM_KEYS_DEF    = 4;
  localparam int HOLD_CYCLES_DEF = 50000;
  localparam int MAX_KEYS        = 16;
  localparam int IDX_W           = 4;

  // Fixed-priority pick: the lowest set bit wins, all-zero returns 0.
  function automatic logic [IDX_W-1:0] lowest_set_index(input logic [MAX_KEYS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_edge_latch.sv
// Per-key rising-edge detector with a one-deep pending flag; flags a lost
// press when a new edge arrives while a previous one is still waiting.
module key_edge_latch
  import key_cmd_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic key_level_in,
  input  logic consume_in,
  output logic rise_out,
  output logic pending_out,
  output logic drop_out
);

  logic key_d_q;
  logic key_d_d;
  logic pending_q;
  logic pending_d;

  // Edge detection and pending bookkeeping.
  always_comb begin
    key_d_d   = key_level_in;
    rise_out  = key_level_in & ~key_d_q;
    drop_out  = 1'b0;
    pending_d = pending_q;
    if (consume_in) begin
      // Selection by the arbiter absorbs both the stored and a same-cycle edge.
      pending_d = 1'b0;
    end else if (rise_out) begin
      pending_d = 1'b1;
      drop_out  = pending_q;
    end else begin
      pending_d = pending_q;
    end
  end

  // Key history resets high so a key held through reset yields no edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      key_d_q   <= 1'b1;
      pending_q <= 1'b0;
    end else begin
      key_d_q   <= key_d_d;
      pending_q <= pending_d;
    end
  end

  assign pending_out = pending_q;

endmodule

// File: rtl/key_cmd_scheduler.sv
// Serialises debounced key presses into short/long-press commands delivered
// one at a time over a valid/ack handshake, lowest key index first.
module key_cmd_scheduler
  import key_cmd_pkg::*;
#(
  parameter int NUM_KEYS    = NUM_KEYS_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CMD_W       = 2,
  parameter int CNT_W       = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [NUM_KEYS-1:0] key_level_in,
  output logic                cmd_valid_out,
  output logic [CMD_W-1:0]    cmd_id_out,
  output logic                cmd_long_out,
  input  logic                cmd_ack_in,
  output logic                busy_out,
  output logic                dropped_out
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  logic [NUM_KEYS-1:0] rise_s;
  logic [NUM_KEYS-1:0] pending_s;
  logic [NUM_KEYS-1:0] drop_s;
  logic [NUM_KEYS-1:0] consume_s;
  logic [NUM_KEYS-1:0] req_s;
  logic [CMD_W-1:0]    pick_s;

  state_e           state_q;
  state_e           state_d;
  logic [CMD_W-1:0] sel_q;
  logic [CMD_W-1:0] sel_d;
  logic             long_q;
  logic             long_d;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic             valid_q;
  logic             valid_d;
  logic             busy_q;
  logic             busy_d;
  logic             dropped_q;
  logic             dropped_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_edge_latch u_latch (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .key_level_in (key_level_in[i]),
      .consume_in   (consume_s[i]),
      .rise_out     (rise_s[i]),
      .pending_out  (pending_s[i]),
      .drop_out     (drop_s[i])
    );
  end

  // Arbitration, next-state and registered-output computation.
  always_comb begin
    req_s      = pending_s | rise_s;
    pick_s     = CMD_W'(lowest_set_index(MAX_KEYS'(req_s)));
    consume_s  = '0;
    state_d    = state_q;
    sel_d      = sel_q;
    long_d     = long_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_s) begin
          consume_s[pick_s] = 1'b1;
          sel_d             = pick_s;
          long_d            = 1'b0;
          // A pending key already released goes straight out as a short press.
          if (key_level_in[pick_s]) begin
            state_d    = TRACK;
            hold_cnt_d = '0;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      TRACK: begin
        if (key_level_in[sel_q]) begin
          if (hold_cnt_q < HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end else begin
          state_d = ISSUE;
          long_d  = (hold_cnt_q >= HOLD_MAX);
        end
      end
      ISSUE: begin
        if (cmd_ack_in) begin
          state_d = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d   = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
    dropped_d = |drop_s;
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      long_q     <= 1'b0;
      hold_cnt_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      long_q     <= long_d;
      hold_cnt_q <= hold_cnt_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  assign cmd_valid_out = valid_q;
  assign cmd_id_out    = sel_q;
  assign cmd_long_out  = long_q;
  assign busy_out      = busy_q;
  assign dropped_out   = dropped_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Scoreboard bench for key_cmd_scheduler: directed key waveforms push the
// expected commands; a monitor pops and compares each command as it appears.
module tb_key_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst_in;
  logic [3:0] key_level_in;
  logic       cmd_valid_out;
  logic [1:0] cmd_id_out;
  logic       cmd_long_out;
  logic       cmd_ack_in;
  logic       busy_out;
  logic       dropped_out;

  int total = 0;
  int bad = 0;
  int drop_cnt = 0;
  int ack_delay = 0;
  logic force_ack = 1'b0;
  logic [2:0] sb_q[$];

  int   vcnt = 0;
  logic seen = 1'b0;
  logic want_ack = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_rst = 1'b1;
  logic [2:0] exp_cmd;
  int   d0;

  key_cmd_scheduler #(
    .NUM_KEYS    (4),
    .HOLD_CYCLES (8),
    .CMD_W       (2),
    .CNT_W       (16)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .key_level_in  (key_level_in),
    .cmd_valid_out (cmd_valid_out),
    .cmd_id_out    (cmd_id_out),
    .cmd_long_out  (cmd_long_out),
    .cmd_ack_in    (cmd_ack_in),
    .busy_out      (busy_out),
    .dropped_out   (dropped_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input int id, input int lng);
    sb_q.push_back({id[1:0], lng[0]});
  endtask

  // Waits until every expected command was seen and the block is idle again.
  task automatic wait_done(input string nm, input int maxc);
    int n;
    n = 0;
    while (!(sb_q.size() == 0 && !busy_out && !cmd_valid_out) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(n < maxc), 1);
    step();
  endtask

  task automatic wait_valid(input string nm, input int maxc);
    int n;
    n = 0;
    while (!cmd_valid_out && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(n < maxc), 1);
  endtask

  // Monitor: pops the scoreboard on each new command and drives the ack.
  initial begin
    cmd_ack_in = 1'b0;
    forever begin
      @(negedge clk);
      if (dropped_out === 1'b1) drop_cnt++;
      if (prev_valid && !cmd_valid_out && !prev_rst)
        chk("valid_held_until_ack", int'(prev_ack), 1);
      if (cmd_valid_out && !seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: got id=%0d long=%0d required no command",
                   cmd_id_out, cmd_long_out);
        end else begin
          exp_cmd = sb_q.pop_front();
          chk("cmd_id", int'(cmd_id_out), int'(exp_cmd[2:1]));
          chk("cmd_long", int'(cmd_long_out), int'(exp_cmd[0]));
        end
      end else if (!cmd_valid_out) begin
        seen = 1'b0;
      end
      want_ack = cmd_valid_out && (vcnt == ack_delay);
      if (cmd_valid_out) vcnt++;
      else vcnt = 0;
      cmd_ack_in = want_ack | force_ack;
      prev_valid = cmd_valid_out;
      prev_ack   = cmd_ack_in;
      prev_rst   = rst_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in       = 1'b1;
    key_level_in = 4'b0000;
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid", int'(cmd_valid_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_dropped", int'(dropped_out), 0);
    chk("rst_id", int'(cmd_id_out), 0);
    chk("rst_long", int'(cmd_long_out), 0);
    step();
    rst_in = 1'b0;
    repeat (2) step();

    // 1: short press of key 2, ack two cycles after valid
    ack_delay = 2;
    expect_cmd(2, 0);
    key_level_in = 4'b0100;
    repeat (3) step();
    key_level_in = 4'b0000;
    wait_done("s1_done", 60);
    chk("s1_busy_after", int'(busy_out), 0);
    chk("s1_valid_after", int'(cmd_valid_out), 0);

    // 2: long press of key 1, immediate ack
    ack_delay = 0;
    expect_cmd(1, 1);
    key_level_in = 4'b0010;
    repeat (19) step();
    @(negedge clk);
    chk("s2_no_valid_while_held", int'(cmd_valid_out), 0);
    @(posedge clk);
    #1;
    key_level_in = 4'b0000;
    @(negedge clk);
    chk("s2_valid_not_early", int'(cmd_valid_out), 0);
    @(negedge clk);
    chk("s2_valid_rise", int'(cmd_valid_out), 1);
    wait_done("s2_done", 60);

    // 3: keys 3 and 0 together, each held two cycles
    ack_delay = 1;
    d0 = drop_cnt;
    expect_cmd(0, 0);
    expect_cmd(3, 0);
    key_level_in = 4'b1001;
    repeat (2) step();
    key_level_in = 4'b0000;
    wait_done("s3_done", 60);
    chk("s3_no_drop", drop_cnt - d0, 0);

    // 4: key 2 pulses twice while key 0 is tracked -> one drop, one key-2 command
    ack_delay = 0;
    d0 = drop_cnt;
    expect_cmd(0, 1);
    expect_cmd(2, 0);
    key_level_in = 4'b0001;
    repeat (3) step();
    key_level_in = 4'b0101;
    step();
    key_level_in = 4'b0001;
    step();
    key_level_in = 4'b0101;
    step();
    key_level_in = 4'b0001;
    repeat (15) step();
    key_level_in = 4'b0000;
    wait_done("s4_done", 80);
    chk("s4_one_drop_cycle", drop_cnt - d0, 1);

    // 5: key 1 held through reset produces nothing
    rst_in       = 1'b1;
    key_level_in = 4'b0010;
    repeat (4) step();
    rst_in = 1'b0;
    repeat (10) begin
      step();
      @(negedge clk);
      chk("s5_no_valid", int'(cmd_valid_out), 0);
      chk("s5_no_busy", int'(busy_out), 0);
    end
    step();
    key_level_in = 4'b0000;
    repeat (5) step();
    chk("s5_valid_after_release", int'(cmd_valid_out), 0);

    // 6: reset while a command is offered, plus a pending key 1
    ack_delay = 1000;
    expect_cmd(3, 0);
    key_level_in = 4'b1000;
    step();
    key_level_in = 4'b0000;
    wait_valid("s6_valid_seen", 20);
    step();
    key_level_in = 4'b0010;
    step();
    key_level_in = 4'b0000;
    step();
    chk("s6_valid_before_rst", int'(cmd_valid_out), 1);
    rst_in = 1'b1;
    step();
    @(negedge clk);
    chk("s6_valid_dropped", int'(cmd_valid_out), 0);
    chk("s6_busy_dropped", int'(busy_out), 0);
    step();
    rst_in    = 1'b0;
    ack_delay = 0;
    force_ack = 1'b1;
    repeat (2) step();
    force_ack = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("s6_no_cmd_after_rst", int'(cmd_valid_out), 0);
      step();
    end
    chk("s6_busy_idle", int'(busy_out), 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
